// File: rtl/ll_fifo_scheduler.sv
// ll_fifo_scheduler
// Front end for a shared linked-list FIFO holding NUM_FIFOS virtual queues in
// DEPTH shared entries. NUM_FIFOS valid/ready producers are granted the single
// push port in round-robin order. Each queue is capped at QUOTA entries.
// Pops are scheduled round-robin across non-empty queues into a registered
// valid/ready output stage.
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   in_valid_i/in_data_i/in_ready_o   producer side, in_ready_o is one-hot
//   ll_push_o/ll_push_sel_o/ll_data_in_o   push port of the linked-list FIFO
//   ll_pop_o/ll_pop_sel_o              pop port of the linked-list FIFO
//   ll_full_i, ll_empty_i, ll_data_out_i   status and head data from the FIFO
//   out_valid_o/out_data_o/out_sel_o/out_ready_i   registered consumer side
//   occ_o              per-queue occupancy, queue i at [i*CNT_WIDTH +: CNT_WIDTH]
module ll_fifo_scheduler #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int NUM_FIFOS = 2,
  parameter int QUOTA     = 3,
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS),
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_FIFOS-1:0]           in_valid_i,
  input  logic [NUM_FIFOS*WIDTH-1:0]     in_data_i,
  output logic [NUM_FIFOS-1:0]           in_ready_o,
  output logic                           ll_push_o,
  output logic [SEL_WIDTH-1:0]           ll_push_sel_o,
  output logic [WIDTH-1:0]               ll_data_in_o,
  output logic                           ll_pop_o,
  output logic [SEL_WIDTH-1:0]           ll_pop_sel_o,
  input  logic                           ll_full_i,
  input  logic [NUM_FIFOS-1:0]           ll_empty_i,
  input  logic [WIDTH-1:0]               ll_data_out_i,
  output logic                           out_valid_o,
  output logic [WIDTH-1:0]               out_data_o,
  output logic [SEL_WIDTH-1:0]           out_sel_o,
  input  logic                           out_ready_i,
  output logic [NUM_FIFOS*CNT_WIDTH-1:0] occ_o
);

  localparam int SW1 = SEL_WIDTH + 1;
  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_FIFOS - 1);
  localparam logic [CNT_WIDTH-1:0] QUOTA_C  = CNT_WIDTH'(QUOTA);

  logic [SEL_WIDTH-1:0] push_ptr_q, push_ptr_d;
  logic [SEL_WIDTH-1:0] pop_ptr_q, pop_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [SEL_WIDTH-1:0] out_sel_q, out_sel_d;
  logic [CNT_WIDTH-1:0] occ_q [NUM_FIFOS];
  logic [CNT_WIDTH-1:0] occ_d [NUM_FIFOS];

  logic [NUM_FIFOS-1:0] eligible;
  logic [WIDTH-1:0]     in_data_arr [NUM_FIFOS];
  logic                 push_found, pop_found, pop_fire;
  logic [SEL_WIDTH-1:0] push_idx, pop_idx;

  // First requester at or after ptr, wrapping at NUM_FIFOS so unused select
  // codes are never produced. Returns {found, index}.
  function automatic logic [SEL_WIDTH:0] rr_pick(input logic [SEL_WIDTH-1:0] ptr,
                                                 input logic [NUM_FIFOS-1:0] req);
    logic [SEL_WIDTH:0]   cand;
    logic                 found;
    logic [SEL_WIDTH-1:0] sel;
    found = 1'b0;
    sel   = ptr;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      cand = {1'b0, ptr} + SW1'(k);
      if (cand >= SW1'(NUM_FIFOS)) cand = cand - SW1'(NUM_FIFOS);
      if (!found && req[cand[SEL_WIDTH-1:0]]) begin
        found = 1'b1;
        sel   = cand[SEL_WIDTH-1:0];
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [SEL_WIDTH-1:0] next_sel(input logic [SEL_WIDTH-1:0] s);
    return (s == LAST_SEL) ? '0 : s + 1'b1;
  endfunction

  // Eligibility uses registered occupancy only, so a same-cycle pop never
  // frees room for the push in that cycle.
  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_queue
    assign eligible[g]    = in_valid_i[g] & ~ll_full_i & (occ_q[g] < QUOTA_C);
    assign in_data_arr[g] = in_data_i[g*WIDTH +: WIDTH];
    assign occ_o[g*CNT_WIDTH +: CNT_WIDTH] = occ_q[g];
  end

  always_comb begin
    {push_found, push_idx} = rr_pick(push_ptr_q, eligible);
    {pop_found, pop_idx}   = rr_pick(pop_ptr_q, ~ll_empty_i);
  end

  assign pop_fire = pop_found & (~out_valid_q | out_ready_i);

  // Handshakes are held low during reset; the FIFO status inputs may still
  // show stale contents until the FIFO itself has been cleared.
  always_comb begin
    in_ready_o    = '0;
    ll_push_o     = 1'b0;
    ll_pop_o      = 1'b0;
    ll_push_sel_o = push_idx;
    ll_data_in_o  = in_data_arr[push_idx];
    ll_pop_sel_o  = pop_idx;
    if (!rst_i) begin
      if (push_found) begin
        in_ready_o[push_idx] = 1'b1;
        ll_push_o            = 1'b1;
      end
      ll_pop_o = pop_fire;
    end
  end

  always_comb begin
    logic push_hit;
    logic pop_hit;
    push_hit    = 1'b0;
    pop_hit     = 1'b0;
    push_ptr_d  = push_ptr_q;
    pop_ptr_d   = pop_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;

    if (push_found) push_ptr_d = next_sel(push_idx);

    if (pop_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = ll_data_out_i;
      out_sel_d   = pop_idx;
      pop_ptr_d   = next_sel(pop_idx);
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    for (int i = 0; i < NUM_FIFOS; i++) begin
      push_hit = push_found && (push_idx == SEL_WIDTH'(i));
      pop_hit  = pop_fire && (pop_idx == SEL_WIDTH'(i));
      occ_d[i] = occ_q[i];
      if (push_hit && !pop_hit)      occ_d[i] = occ_q[i] + 1'b1;
      else if (!push_hit && pop_hit) occ_d[i] = occ_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      push_ptr_q  <= '0;
      pop_ptr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      for (int i = 0; i < NUM_FIFOS; i++) occ_q[i] <= '0;
    end else begin
      push_ptr_q  <= push_ptr_d;
      pop_ptr_q   <= pop_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      for (int i = 0; i < NUM_FIFOS; i++) occ_q[i] <= occ_d[i];
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_ll_fifo_scheduler.sv
// Testbench for ll_fifo_scheduler. Emulates the shared linked-list FIFO with
// per-queue SystemVerilog queues; the same queues hold the reference state
// (occupancy = queue length). Directed table rows, one hand-written async
// reset sequence, then randomized traffic checked against the reference model.
module tb_ll_fifo_scheduler;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int N  = 2;
  localparam int Q  = 3;
  localparam int SW = 1;
  localparam int CW = 3;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    in_valid_i = '0;
  logic [N*W-1:0]  in_data_i = '0;
  logic [N-1:0]    in_ready_o;
  logic            ll_push_o;
  logic [SW-1:0]   ll_push_sel_o;
  logic [W-1:0]    ll_data_in_o;
  logic            ll_pop_o;
  logic [SW-1:0]   ll_pop_sel_o;
  logic            ll_full_i = 1'b0;
  logic [N-1:0]    ll_empty_i = '1;
  logic [W-1:0]    ll_data_out_i = '0;
  logic            out_valid_o;
  logic [W-1:0]    out_data_o;
  logic [SW-1:0]   out_sel_o;
  logic            out_ready_i = 1'b0;
  logic [N*CW-1:0] occ_o;

  ll_fifo_scheduler #(.WIDTH(W), .DEPTH(D), .NUM_FIFOS(N), .QUOTA(Q)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .ll_push_o(ll_push_o), .ll_push_sel_o(ll_push_sel_o), .ll_data_in_o(ll_data_in_o),
    .ll_pop_o(ll_pop_o), .ll_pop_sel_o(ll_pop_sel_o),
    .ll_full_i(ll_full_i), .ll_empty_i(ll_empty_i), .ll_data_out_i(ll_data_out_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_sel_o(out_sel_o),
    .out_ready_i(out_ready_i), .occ_o(occ_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: queue contents, RR pointers, output stage.
  logic [W-1:0] mq [N][$];
  int           r_pp, r_pop, r_os;
  logic         r_ov;
  logic [W-1:0] r_od;

  typedef struct {
    logic         r;
    logic [N-1:0] iv;
    logic [W-1:0] d0, d1;
    logic         ordy;
    logic [N-1:0] ir;
    logic         pop;
    logic         ov;
    logic [W-1:0] od;
    int           o0, o1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [N-1:0] iv, logic [W-1:0] d0, logic [W-1:0] d1,
                              logic ordy, logic [N-1:0] ir, logic pop, logic ov,
                              logic [W-1:0] od, int o0, int o1);
    vec_t v;
    v.r = r; v.iv = iv; v.d0 = d0; v.d1 = d1; v.ordy = ordy;
    v.ir = ir; v.pop = pop; v.ov = ov; v.od = od; v.o0 = o0; v.o1 = o1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int occ_of(int i);
    return int'(occ_o[i*CW +: CW]);
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    r_pp = 0; r_pop = 0; r_ov = 1'b0; r_od = '0; r_os = 0;
  endtask

  function automatic int total_occ();
    int t = 0;
    for (int i = 0; i < N; i++) t += mq[i].size();
    return t;
  endfunction

  task automatic drive_env();
    ll_full_i = (total_occ() >= D);
    for (int i = 0; i < N; i++) ll_empty_i[i] = (mq[i].size() == 0);
  endtask

  // FIFO head data follows whatever queue the DUT is selecting to pop.
  task automatic drive_head();
    int ps;
    ps = int'(ll_pop_sel_o);
    if (ps < N && mq[ps].size() > 0) ll_data_out_i = mq[ps][0];
    else ll_data_out_i = W'($urandom);
  endtask

  // One clock cycle: drive at negedge, compare before the next posedge,
  // then advance the reference model.
  task automatic do_cycle(input logic r, input logic [N-1:0] iv, input logic [N*W-1:0] id,
                          input logic ordy);
    logic exp_push, exp_pop;
    int eg, ej, total;
    logic [W-1:0] v;
    @(negedge clk_i);
    rst_i = r; in_valid_i = iv; in_data_i = id; out_ready_i = ordy;
    if (r) ref_reset();
    drive_env();
    #1;
    drive_head();
    #1;
    total = total_occ();
    exp_push = 1'b0; eg = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (r_pp + k) % N;
      if (!exp_push && iv[i] && total < D && mq[i].size() < Q) begin
        exp_push = 1'b1; eg = i;
      end
    end
    exp_pop = 1'b0; ej = 0;
    if (!r_ov || ordy) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (r_pop + k) % N;
        if (!exp_pop && mq[j].size() > 0) begin
          exp_pop = 1'b1; ej = j;
        end
      end
    end
    if (r) begin
      exp_push = 1'b0; exp_pop = 1'b0;
    end
    chk("in_ready", 32'(in_ready_o), exp_push ? (32'd1 << eg) : 32'd0);
    chk("ll_push", 32'(ll_push_o), 32'(exp_push));
    if (exp_push) begin
      chk("ll_push_sel", 32'(ll_push_sel_o), 32'(eg));
      chk("ll_data_in", 32'(ll_data_in_o), 32'(id[eg*W +: W]));
    end
    chk("ll_pop", 32'(ll_pop_o), 32'(exp_pop));
    if (exp_pop) chk("ll_pop_sel", 32'(ll_pop_sel_o), 32'(ej));
    chk("out_valid", 32'(out_valid_o), 32'(r_ov));
    if (r_ov) begin
      chk("out_data", 32'(out_data_o), 32'(r_od));
      chk("out_sel", 32'(out_sel_o), 32'(r_os));
    end
    for (int i = 0; i < N; i++) chk($sformatf("occ%0d", i), 32'(occ_of(i)), 32'(mq[i].size()));
    if (!r) begin
      if (exp_pop) begin
        v = mq[ej].pop_front();
        r_ov = 1'b1; r_od = v; r_os = ej; r_pop = (ej + 1) % N;
      end else if (r_ov && ordy) begin
        r_ov = 1'b0;
      end
      if (exp_push) begin
        mq[eg].push_back(id[eg*W +: W]);
        r_pp = (eg + 1) % N;
      end
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int n = lo; n < hi; n++) begin
      vec_t v;
      v = vecs[n];
      do_cycle(v.r, v.iv, {v.d1, v.d0}, v.ordy);
      chk($sformatf("row%0d_in_ready", n), 32'(in_ready_o), 32'(v.ir));
      chk($sformatf("row%0d_pop", n), 32'(ll_pop_o), 32'(v.pop));
      chk($sformatf("row%0d_out_valid", n), 32'(out_valid_o), 32'(v.ov));
      if (v.ov) chk($sformatf("row%0d_out_data", n), 32'(out_data_o), 32'(v.od));
      chk($sformatf("row%0d_occ0", n), 32'(occ_of(0)), 32'(v.o0));
      chk($sformatf("row%0d_occ1", n), 32'(occ_of(1)), 32'(v.o1));
    end
  endtask

  initial begin
    ref_reset();
    // r, iv, d0, d1, ordy | in_ready, pop, out_valid, out_data, occ0, occ1
    // reset, then idle
    vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 0, 8'h00, 0, 0));
    // contended push with out_ready=0; first entry drains into the empty output stage
    vecs.push_back(mk(0, 2'b11, 8'hA0, 8'hB0, 0, 2'b01, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 8'hA1, 8'hB0, 0, 2'b10, 1, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 2'b11, 8'hA1, 8'hB1, 0, 2'b01, 0, 1, 8'hA0, 0, 1));
    vecs.push_back(mk(0, 2'b11, 8'hA2, 8'hB1, 0, 2'b10, 0, 1, 8'hA0, 1, 1));
    vecs.push_back(mk(0, 2'b01, 8'hA2, 8'h00, 0, 2'b01, 0, 1, 8'hA0, 1, 2));
    vecs.push_back(mk(0, 2'b11, 8'hA3, 8'hB2, 0, 2'b00, 0, 1, 8'hA0, 2, 2));
    vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 1, 8'hA0, 2, 2));
    vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 1, 8'hB0, 2, 1));
    // quota on q0, then q1 still accepted
    vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 2'b01, 8'hD0, 8'h00, 0, 2'b01, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 2'b01, 8'hD1, 8'h00, 0, 2'b01, 1, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 2'b01, 8'hD2, 8'h00, 0, 2'b01, 0, 1, 8'hD0, 1, 0));
    vecs.push_back(mk(0, 2'b01, 8'hD3, 8'h00, 0, 2'b01, 0, 1, 8'hD0, 2, 0));
    vecs.push_back(mk(0, 2'b01, 8'hD4, 8'h00, 0, 2'b00, 0, 1, 8'hD0, 3, 0));
    vecs.push_back(mk(0, 2'b11, 8'hD4, 8'hE0, 0, 2'b10, 0, 1, 8'hD0, 3, 0));
    // fill X/Y, backpressure, then fair drain X0,Y0,X1,Y1
    vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 8'h50, 8'h60, 0, 2'b01, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 8'h51, 8'h60, 0, 2'b10, 1, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 2'b11, 8'h51, 8'h61, 0, 2'b01, 0, 1, 8'h50, 0, 1));
    vecs.push_back(mk(0, 2'b10, 8'h00, 8'h61, 0, 2'b10, 0, 1, 8'h50, 1, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 1, 8'h50, 1, 2));
    vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 1, 8'h50, 1, 2));
    vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 1, 8'h50, 1, 2));
    vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 1, 8'h50, 1, 2));
    vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 1, 8'h60, 1, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 1, 8'h51, 0, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 1, 8'h61, 0, 0));
    vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 8'h00, 0, 0));

    run_rows(0, 12);

    // Async reset between edges with occ={2,1}, out_valid=1 and push_ptr=1.
    @(negedge clk_i);
    in_valid_i = '0; out_ready_i = 1'b0;
    drive_env();
    #1;
    drive_head();
    chk("pre_rst_out_valid", 32'(out_valid_o), 32'd1);
    chk("pre_rst_occ0", 32'(occ_of(0)), 32'd2);
    chk("pre_rst_occ1", 32'(occ_of(1)), 32'd1);
    #1;
    rst_i = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("async_rst_occ0", 32'(occ_of(0)), 32'd0);
    chk("async_rst_occ1", 32'(occ_of(1)), 32'd0);
    chk("async_rst_ll_pop", 32'(ll_pop_o), 32'd0);
    ref_reset();
    do_cycle(1'b1, 2'b00, '0, 1'b0);
    do_cycle(1'b0, 2'b11, {8'hB9, 8'hA9}, 1'b0);
    chk("post_rst_grant_q0", 32'(in_ready_o), 32'b01);
    do_cycle(1'b0, 2'b11, {8'hB9, 8'hAA}, 1'b0);
    chk("post_rst_grant_q1", 32'(in_ready_o), 32'b10);

    run_rows(12, vecs.size());

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      logic r;
      logic [N-1:0] iv;
      logic ordy;
      r    = ($urandom_range(0, 299) == 0);
      iv   = N'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      if ((c / 200) % 2 == 1) ordy = ($urandom_range(0, 3) == 0);
      do_cycle(r, iv, (N*W)'($urandom), ordy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
